// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Iterative multiply/divide unit with architectural HI/LO registers.
//             Shift-add multiply, restoring divide, BITS_PER_CYCLE bits/step.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             readHiLo,
  input  logic             writeHi,
  input  logic             writeLo,
  input  logic [WIDTH-1:0] writeData,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stallRequest,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int BPC   = BITS_PER_CYCLE;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_hi;     // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;     // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] mag_b;      // multiplicand or divisor magnitude
  logic             is_div;
  logic             neg_q;      // product / quotient sign
  logic             neg_r;      // remainder sign
  logic             div_zero;   // divisor was zero: quotient must stay all ones

  // Operand magnitude capture at start
  logic             signed_op;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;

  // One iteration step of the shared datapath
  logic [WIDTH-1:0]     step_hi;
  logic [WIDTH-1:0]     step_lo;
  logic [WIDTH+BPC-1:0] mul_sum;
  logic [WIDTH:0]       div_ext;

  // Sign fix-up applied to the final step's output
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_q;
  logic [WIDTH-1:0]   fix_r;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Stall the execution stage on any unit/HI/LO access while an operation runs
  assign stallRequest = busy && (start || readHiLo || writeHi || writeLo);

  // Signed ops work on magnitudes; unsigned ops take operands as-is
  always_comb begin
    signed_op = ~op[0];
    sign_a    = signed_op && operandA[WIDTH-1];
    sign_b    = signed_op && operandB[WIDTH-1];
    mag_a_in  = sign_a ? ('0 - operandA) : operandA;
    mag_b_in  = sign_b ? ('0 - operandB) : operandB;
  end

  // Combinational step: BPC restoring-divide iterations or one BPC-bit shift-add
  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    mul_sum = '0;
    div_ext = '0;
    if (is_div) begin
      for (int k = 0; k < BPC; k++) begin
        div_ext = {step_hi, step_lo[WIDTH-1]};
        step_lo = {step_lo[WIDTH-2:0], 1'b0};
        if (div_ext >= {1'b0, mag_b}) begin
          div_ext    = div_ext - {1'b0, mag_b};
          step_lo[0] = 1'b1;
        end
        step_hi = div_ext[WIDTH-1:0];
      end
    end else begin
      mul_sum = {{BPC{1'b0}}, acc_hi};
      for (int k = 0; k < BPC; k++) begin
        if (acc_lo[k]) begin
          mul_sum = mul_sum + ({{BPC{1'b0}}, mag_b} << k);
        end
      end
      step_hi = mul_sum[WIDTH+BPC-1:BPC];
      step_lo = {mul_sum[BPC-1:0], acc_lo[WIDTH-1:BPC]};
    end
  end

  // Final-step sign correction; a zero divisor leaves the quotient as all ones
  // and the negated |A| remainder reproduces operandA exactly
  always_comb begin
    fix_prod = neg_q ? ('0 - {step_hi, step_lo}) : {step_hi, step_lo};
    fix_q    = (neg_q && !div_zero) ? ('0 - step_lo) : step_lo;
    fix_r    = neg_r ? ('0 - step_hi) : step_hi;
    res_hi   = is_div ? fix_r : fix_prod[2*WIDTH-1:WIDTH];
    res_lo   = is_div ? fix_q : fix_prod[WIDTH-1:0];
  end

  // Sequencer FSM, iteration registers and HI/LO register file
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mag_b    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (writeHi) hi <= writeData;
          if (writeLo) lo <= writeData;
          if (start && !flush) begin
            state    <= RUN;
            busy     <= 1'b1;
            count    <= CNT_W'(STEPS);
            acc_hi   <= '0;
            acc_lo   <= mag_a_in;
            mag_b    <= mag_b_in;
            is_div   <= op[1];
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            div_zero <= (operandB == '0);
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              hi    <= res_hi;
              lo    <= res_lo;
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
